// File: rtl/fcs_pkg.sv
// Shared types and helpers for the FCS request arbiter and engine controller.
package fcs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RUN,
    ST_FINISH,
    ST_REJECT
  } fcs_state_e;

  localparam int unsigned DEF_MAX_IN_WIDTH = 1024;
  localparam int unsigned DEF_MIN_IN_WIDTH = 64;

  function automatic int unsigned size_w(input int unsigned max_width);
    return $clog2(max_width);
  endfunction

  function automatic logic size_legal(input int unsigned size,
                                      input int unsigned min_w,
                                      input int unsigned max_w);
    return (size >= min_w) && (size <= max_w);
  endfunction

endpackage

// File: rtl/fcs_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module fcs_rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               any_o,
  output logic [ID_W-1:0]    win_o
);

  logic [ID_W-1:0] idx;

  assign any_o = |req_i;

  // Scan from the farthest offset down so the nearest pending request wins.
  always_comb begin
    win_o = '0;
    idx   = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_i) + k) % int'(NUM_REQ));
      if (req_i[idx]) win_o = idx;
    end
  end

endmodule

// File: rtl/fcs_req_arbiter.sv
// Round-robin arbiter sharing one FCS engine; screens sizes, starts the engine, tracks busy.
// States: IDLE pick, ISSUE start strobe, WAIT_ACK await busy, RUN engine working, FINISH/REJECT pulse.
module fcs_req_arbiter
  import fcs_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned MAX_IN_WIDTH = DEF_MAX_IN_WIDTH,
  parameter  int unsigned MIN_IN_WIDTH = DEF_MIN_IN_WIDTH,
  parameter  int unsigned ACK_TIMEOUT  = 16,
  localparam int unsigned SIZE_W       = size_w(MAX_IN_WIDTH),
  localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*SIZE_W-1:0] req_size,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ID_W-1:0]           active_id,
  output logic                      fcs_valid,
  output logic [SIZE_W-1:0]         fcs_size,
  input  logic                      fcs_busy,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      arb_busy
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  fcs_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q, done_q, err_q;
  logic [ID_W-1:0]    owner_q, rr_ptr_q, rr_ptr_d;
  logic [SIZE_W-1:0]  fcs_size_q, sel_size_d;
  logic               fcs_valid_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               any_req, size_ok_d;
  logic [ID_W-1:0]    pick_id;
  logic [NUM_REQ-1:0] pick_1h, owner_1h;
  logic [SIZE_W-1:0]  size_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign size_arr[g] = req_size[g*SIZE_W +: SIZE_W];
  end

  fcs_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (any_req),
    .win_o (pick_id)
  );

  assign sel_size_d = size_arr[pick_id];
  assign size_ok_d  = size_legal(32'(sel_size_d), MIN_IN_WIDTH, MAX_IN_WIDTH);
  assign pick_1h    = NUM_REQ'(1) << pick_id;
  assign owner_1h   = NUM_REQ'(1) << owner_q;
  assign rr_ptr_d   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      fcs_size_q  <= '0;
      fcs_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q      <= '0;
      err_q       <= '0;
      fcs_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q    <= pick_id;
            fcs_size_q <= sel_size_d;
            if (size_ok_d) begin
              state_q     <= ST_ISSUE;
              grant_q     <= pick_1h;
              fcs_valid_q <= 1'b1;
            end else begin
              state_q <= ST_REJECT;
              err_q   <= pick_1h;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_ACK;
          cnt_q   <= '0;
        end
        ST_WAIT_ACK: begin
          if (fcs_busy) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_FINISH;
            err_q   <= owner_1h;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!fcs_busy) begin
            state_q <= ST_FINISH;
            done_q  <= owner_1h;
          end
        end
        ST_FINISH, ST_REJECT: begin
          state_q  <= ST_IDLE;
          grant_q  <= '0;
          rr_ptr_q <= rr_ptr_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign active_id = (grant_q != '0) ? owner_q : '0;
  assign fcs_valid = fcs_valid_q;
  assign fcs_size  = fcs_size_q;
  assign done      = done_q;
  assign err       = err_q;
  assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fcs_req_arbiter.sv
// Directed bench for fcs_req_arbiter: engine model plus start/completion scoreboard.
module tb_fcs_req_arbiter;

  localparam int NR     = 4;
  localparam int SW     = 10;
  localparam int IW     = 2;
  localparam int ACK_TO = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NR-1:0]   req_valid;
  logic [NR*SW-1:0] req_size;
  logic [SW-1:0]   sz [NR];
  logic [NR-1:0]   grant, done, err;
  logic [IW-1:0]   active_id;
  logic            fcs_valid, arb_busy;
  logic [SW-1:0]   fcs_size;
  logic            fcs_busy;

  int eng_cnt;
  bit ack_en;
  int busy_len;

  typedef struct {
    int id;
    int size;
    bit is_err;
    bit started;
  } job_t;

  job_t start_q[$];
  job_t end_q[$];
  int   cyc, exp_end_cyc, n_assert, n_fail;
  logic [NR-1:0] rearm_en, rearm_a, rearm_b;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_size[g*SW +: SW] = sz[g];
  end

  fcs_req_arbiter #(
    .NUM_REQ(NR), .MAX_IN_WIDTH(1024), .MIN_IN_WIDTH(64), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_size(req_size),
    .grant(grant), .active_id(active_id), .fcs_valid(fcs_valid), .fcs_size(fcs_size),
    .fcs_busy(fcs_busy), .done(done), .err(err), .arb_busy(arb_busy)
  );

  // Engine: busy rises the cycle after the start strobe and holds for busy_len cycles.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fcs_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (fcs_valid && ack_en) begin
      fcs_busy <= 1'b1;
      eng_cnt  <= busy_len - 1;
    end else if (fcs_busy) begin
      if (eng_cnt == 0) fcs_busy <= 1'b0;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int id);
    return 32'(1) << id;
  endfunction

  task automatic exp_job(input int id, input int size, input bit is_err, input bit started);
    job_t j;
    j = '{id, size, is_err, started};
    if (started) start_q.push_back(j);
    end_q.push_back(j);
  endtask

  task automatic step();
    job_t e;
    @(negedge CLK);
    cyc++;
    req_valid |= rearm_b;
    rearm_b = rearm_a;
    rearm_a = '0;
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("done_err_exclusive", 32'((|done) && (|err)), 32'd0);
    chk("done_onehot0", 32'($onehot0(done)), 32'd1);
    chk("err_onehot0", 32'($onehot0(err)), 32'd1);
    if (fcs_valid) begin
      if (start_q.size() == 0) begin
        chk("unexpected_fcs_valid", 32'(fcs_valid), 32'd0);
      end else begin
        e = start_q.pop_front();
        chk("start_grant", 32'(grant), oh(e.id));
        chk("start_active_id", 32'(active_id), 32'(e.id));
        chk("start_fcs_size", 32'(fcs_size), 32'(e.size));
        exp_end_cyc = ack_en ? cyc + 2 + busy_len : cyc + 1 + ACK_TO;
      end
    end
    if ((done | err) != '0) begin
      if (end_q.size() == 0) begin
        chk("unexpected_done_err", 32'({done, err}), 32'd0);
      end else begin
        e = end_q.pop_front();
        chk("end_done", 32'(done), e.is_err ? 32'd0 : oh(e.id));
        chk("end_err", 32'(err), e.is_err ? oh(e.id) : 32'd0);
        chk("end_cycle", 32'(cyc), 32'(exp_end_cyc));
        chk("end_grant", 32'(grant), e.started ? oh(e.id) : 32'd0);
      end
      for (int i = 0; i < NR; i++) begin
        if (done[i] || err[i]) begin
          req_valid[i] = 1'b0;
          if (rearm_en[i]) begin
            rearm_a[i]  = 1'b1;
            rearm_en[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((arb_busy || end_q.size() != 0 || req_valid != '0 || rearm_a != '0 || rearm_b != '0)
           && n < budget) begin
      step();
      n++;
    end
    chk("idle_arb_busy", 32'(arb_busy), 32'd0);
    chk("idle_pending_jobs", 32'(end_q.size()), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_fcs_valid"}, 32'(fcs_valid), 32'd0);
    chk({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
    chk({tag, "_active_id"}, 32'(active_id), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    req_valid = '0;
    rearm_en = '0;
    rearm_a = '0;
    rearm_b = '0;
    start_q.delete();
    end_q.delete();
    #1;
    chk_quiet("reset");
    chk("reset_fcs_size", 32'(fcs_size), 32'd0);
    step();
    RST = 1'b1;
  endtask

  initial begin
    req_valid = '0;
    for (int i = 0; i < NR; i++) sz[i] = '0;
    ack_en = 1'b1;
    busy_len = 5;
    cyc = 0;
    exp_end_cyc = 0;
    n_assert = 0;
    n_fail = 0;
    rearm_en = '0;
    rearm_a = '0;
    rearm_b = '0;
    #2;

    // single request, engine busy 5 cycles
    do_reset();
    sz[1] = 10'd512;
    exp_job(1, 512, 1'b0, 1'b1);
    req_valid = 4'b0010;
    step();
    chk("single_fcs_valid_latency", 32'(fcs_valid), 32'd1);
    wait_idle(100);
    chk("single_grant_released", 32'(grant), 32'd0);

    // contention: all pending, requester 0 re-requests once
    do_reset();
    for (int i = 0; i < NR; i++) sz[i] = 10'd128;
    exp_job(0, 128, 1'b0, 1'b1);
    exp_job(1, 128, 1'b0, 1'b1);
    exp_job(2, 128, 1'b0, 1'b1);
    exp_job(3, 128, 1'b0, 1'b1);
    exp_job(0, 128, 1'b0, 1'b1);
    rearm_en = 4'b0001;
    req_valid = 4'b1111;
    wait_idle(300);

    // size reject twice on requester 2, then pointer should sit at 3
    do_reset();
    sz[2] = 10'd32;
    exp_job(2, 32, 1'b1, 1'b0);
    req_valid = 4'b0100;
    exp_end_cyc = cyc + 1;
    wait_idle(20);
    sz[2] = 10'd0;
    exp_job(2, 0, 1'b1, 1'b0);
    req_valid = 4'b0100;
    exp_end_cyc = cyc + 1;
    wait_idle(20);
    sz[2] = 10'd128;
    sz[3] = 10'd128;
    exp_job(3, 128, 1'b0, 1'b1);
    exp_job(2, 128, 1'b0, 1'b1);
    req_valid = 4'b1100;
    wait_idle(100);

    // ack timeout: engine never answers
    do_reset();
    ack_en = 1'b0;
    sz[0] = 10'd256;
    sz[1] = 10'd256;
    exp_job(0, 256, 1'b1, 1'b1);
    exp_job(1, 256, 1'b1, 1'b1);
    req_valid = 4'b0011;
    wait_idle(200);
    chk("timeout_grant_released", 32'(grant), 32'd0);
    ack_en = 1'b1;

    // reset in the middle of a run
    do_reset();
    busy_len = 20;
    sz[1] = 10'd512;
    exp_job(1, 512, 1'b0, 1'b1);
    req_valid = 4'b0010;
    repeat (6) step();
    chk("midrun_grant", 32'(grant), 32'h2);
    chk("midrun_arb_busy", 32'(arb_busy), 32'd1);
    RST = 1'b0;
    #1;
    chk_quiet("midrun_reset");
    start_q.delete();
    end_q.delete();
    busy_len = 5;
    sz[2] = 10'd256;
    exp_job(1, 512, 1'b0, 1'b1);
    exp_job(2, 256, 1'b0, 1'b1);
    req_valid = 4'b0110;
    step();
    RST = 1'b1;
    wait_idle(100);

    // boundary sizes
    do_reset();
    sz[0] = 10'd64;
    exp_job(0, 64, 1'b0, 1'b1);
    req_valid = 4'b0001;
    wait_idle(100);
    sz[1] = 10'd63;
    exp_job(1, 63, 1'b1, 1'b0);
    req_valid = 4'b0010;
    exp_end_cyc = cyc + 1;
    wait_idle(20);
    sz[2] = 10'd1023;
    exp_job(2, 1023, 1'b0, 1'b1);
    req_valid = 4'b0100;
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
